mul_issue_ctrl: RTL and testbench
=================================

Name: mul_issue_ctrl

Overview:
- Execute-side controller that sits directly upstream and downstream of the multiplier top.
- Accepts multiply requests from two issue lanes (lane 1 has priority) and captures the operands.
- Drives the multiplier request bus and holds it stable until the multiplier returns ok.
- Captures the result into a one-entry response register with a valid/ready handshake back to execute.
- Handles pipeline flush at any point in the operation.

Parameters:
- DATA_W, 32, operand and result width. The multiplier bus layouts below assume 32.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush; kills any in-flight or buffered operation
- req1_valid  in  1  lane-1 request
- req1_ready  out  1  lane-1 accept
- req1_use_high  in  1  return product[63:32] instead of product[31:0]
- req1_unsigned  in  1  unsigned operands
- req1_x  in  32  multiplicand
- req1_y  in  32  multiplier
- req2_valid, req2_ready, req2_use_high, req2_unsigned, req2_x, req2_y  as lane 1, for lane 2
- mul_req_bus  out  67  {use_mul, use_high, is_unsigned, x[31:0], y[31:0]} to the multiplier
- mul_rsp_bus  in  33  {mul_result[31:0], mul_ok} from the multiplier
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_lane  out  1  0 = lane 1, 1 = lane 2
- rsp_data  out  32  selected product half
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - All captured operand registers = 0.
  - rsp_valid, rsp_lane, rsp_data, busy = 0.
  - mul_req_bus = 0.
  - With flush low, req1_ready = 1 immediately after reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req1_ready = ~flush.
  - req2_ready = ~flush & ~req1_valid.
  - Accept happens on the edge where valid & ready. At that edge, capture {lane, use_high, unsigned, x, y} and go to RUN.
  - If both lanes are valid, lane 1 is accepted and lane 2 sees ready = 0.
- RUN:
  - mul_req_bus = {1, captured fields}, driven from registers and stable for the whole state.
  - All ready outputs = 0.
  - When mul_ok = 1 and flush = 0: rsp_data <= mul_result, rsp_lane <= captured lane, rsp_valid <= 1, go to DONE.
  - The controller waits on mul_ok only and assumes no fixed cycle count.
- DONE:
  - mul_req_bus = 0, so the multiplier sees en low and resets its internal phase.
  - rsp_valid = 1; rsp_data and rsp_lane are held unchanged.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, go to IDLE.
  - No new request is accepted in DONE; the earliest accept is the first IDLE cycle.
- Outside RUN: mul_req_bus = all zeros, including x and y.
- Nominal latency with the current multiplier:
  - Accept edge E0. use_mul is high in cycles 1–3, and mul_ok = 1 in cycle 3.
  - rsp_valid rises in cycle 4.
  - Back-to-back throughput is one result per 5 cycles when rsp_ready is held high.
- Flush has priority over every other event:
  - In any state, flush = 1 sends the FSM to IDLE at the next edge and clears rsp_valid.
  - The captured request is discarded.
  - No request is accepted in a flush cycle.
  - A mul_ok arriving in the same cycle as flush is ignored and no response is produced.
- Reset mid-operation: asynchronous reset forces every output to its reset value immediately, with no clock edge required, and drops the operation.
- rsp_ready is ignored while rsp_valid = 0.
- mul_ok is ignored outside RUN.

Test Plan:
1. Lane 1 signed request, x=0xFFFFFFFD, y=7, use_high=0, accept at E0 -> use_mul=1 in cycles 1–3; rsp_valid=1 in cycle 4 with rsp_data=0xFFFFFFEB and rsp_lane=0.
2. Lane 2 unsigned request, x=y=0xFFFFFFFF, use_high=1 -> rsp_data=0xFFFFFFFE, rsp_lane=1. Repeat signed with use_high=1 -> rsp_data=0x00000000.
3. Both lanes valid in the same cycle (lane 1: 6×7, lane 2: 5×5) -> req1_ready=1 and req2_ready=0. Result 42 with rsp_lane=0 first; lane 2 is accepted in the following IDLE cycle; result 25 with rsp_lane=1.
4. Backpressure: rsp_ready held low 5 cycles after rsp_valid -> rsp_valid and rsp_data held, mul_req_bus=0, both ready=0, busy=1. Raising rsp_ready -> IDLE and busy=0 next cycle.
5. flush in cycle 2 of RUN, and separately flush coincident with mul_ok -> no rsp_valid ever, IDLE next cycle. A new request 3×4 then returns 12 with normal latency.
6. Asynchronous reset asserted mid-RUN, between clock edges -> mul_req_bus, rsp_valid and busy go to 0 before the next edge. After release, req1_ready=1 when flush=0.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// Execute-side multiply issue controller: arbitrates two issue lanes, holds the
// multiplier request bus for the whole operation and buffers one result.
module mul_issue_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_use_high,
  input  logic                  req1_unsigned,
  input  logic [DATA_W-1:0]     req1_x,
  input  logic [DATA_W-1:0]     req1_y,
  input  logic                  req2_valid,
  output logic                  req2_ready,
  input  logic                  req2_use_high,
  input  logic                  req2_unsigned,
  input  logic [DATA_W-1:0]     req2_x,
  input  logic [DATA_W-1:0]     req2_y,
  output logic [2*DATA_W+2:0]   mul_req_bus,
  input  logic [DATA_W:0]       mul_rsp_bus,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_lane,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic                  lane_q, lane_d;
  logic                  use_high_q, use_high_d;
  logic                  uns_q, uns_d;
  logic [DATA_W-1:0]     x_q, x_d, y_q, y_d;
  logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_lane_q, rsp_lane_d;
  logic                  busy_q, busy_d;
  logic [2*DATA_W+2:0]   mul_req_q, mul_req_d;

  logic                  mul_ok;
  logic [DATA_W-1:0]     mul_result;
  logic                  acc1, acc2;

  assign {mul_result, mul_ok} = mul_rsp_bus;

  assign req1_ready = (state_q == IDLE) & ~flush;
  assign req2_ready = (state_q == IDLE) & ~flush & ~req1_valid;
  assign acc1       = req1_valid & req1_ready;
  assign acc2       = req2_valid & req2_ready;

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    use_high_d  = use_high_q;
    uns_d       = uns_q;
    x_d         = x_q;
    y_d         = y_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_lane_d  = rsp_lane_q;

    case (state_q)
      IDLE: begin
        if (acc1) begin
          lane_d     = 1'b0;
          use_high_d = req1_use_high;
          uns_d      = req1_unsigned;
          x_d        = req1_x;
          y_d        = req1_y;
          state_d    = RUN;
        end else if (acc2) begin
          lane_d     = 1'b1;
          use_high_d = req2_use_high;
          uns_d      = req2_unsigned;
          x_d        = req2_x;
          y_d        = req2_y;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (mul_ok && !flush) begin
          rsp_data_d  = mul_result;
          rsp_lane_d  = lane_q;
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides everything, including a same-cycle mul_ok.
    if (flush) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b0;
    end

    busy_d    = (state_d != IDLE);
    mul_req_d = (state_d == RUN) ? {1'b1, use_high_d, uns_d, x_d, y_d} : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lane_q      <= 1'b0;
      use_high_q  <= 1'b0;
      uns_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_lane_q  <= 1'b0;
      busy_q      <= 1'b0;
      mul_req_q   <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      use_high_q  <= use_high_d;
      uns_q       <= uns_d;
      x_q         <= x_d;
      y_q         <= y_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_lane_q  <= rsp_lane_d;
      busy_q      <= busy_d;
      mul_req_q   <= mul_req_d;
    end
  end

  assign mul_req_bus = mul_req_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_lane    = rsp_lane_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Randomised bench for mul_issue_ctrl with a behavioural multiplier and a
// reference product model.
module tb_mul_issue_ctrl;

  logic        clk = 1'b0, reset = 1'b1, flush = 1'b0;
  logic        req1_valid = 1'b0, req1_use_high = 1'b0, req1_unsigned = 1'b0;
  logic [31:0] req1_x = '0, req1_y = '0;
  logic        req2_valid = 1'b0, req2_use_high = 1'b0, req2_unsigned = 1'b0;
  logic [31:0] req2_x = '0, req2_y = '0;
  logic        req1_ready, req2_ready;
  logic [66:0] mul_req_bus;
  logic [32:0] mul_rsp_bus;
  logic        rsp_valid, rsp_lane, busy;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;

  int total = 0;
  int bad   = 0;
  int mul_lat = 3;
  int phase = 0;
  logic        mul_ok_m;
  logic [31:0] mul_res_m;

  mul_issue_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_use_high(req1_use_high),
    .req1_unsigned(req1_unsigned), .req1_x(req1_x), .req1_y(req1_y),
    .req2_valid(req2_valid), .req2_ready(req2_ready), .req2_use_high(req2_use_high),
    .req2_unsigned(req2_unsigned), .req2_x(req2_x), .req2_y(req2_y),
    .mul_req_bus(mul_req_bus), .mul_rsp_bus(mul_rsp_bus),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lane(rsp_lane),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic uh, input logic uns,
                                          input logic [31:0] x, input logic [31:0] y);
    longint p;
    if (uns) p = longint'({32'b0, x}) * longint'({32'b0, y});
    else     p = longint'($signed(x)) * longint'($signed(y));
    return uh ? p[63:32] : p[31:0];
  endfunction

  // Multiplier stand-in: ok fires after mul_lat cycles of use_mul.
  always @(posedge clk) phase <= mul_req_bus[66] ? phase + 1 : 0;
  always_comb begin
    mul_ok_m  = mul_req_bus[66] && (phase == mul_lat - 1);
    mul_res_m = mul_ok_m ? ref_mul(mul_req_bus[65], mul_req_bus[64],
                                   mul_req_bus[63:32], mul_req_bus[31:0]) : 32'h0;
  end
  assign mul_rsp_bus = {mul_res_m, mul_ok_m};

  task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input bit lane, input bit uh, input bit uns,
                         input logic [31:0] x, input logic [31:0] y);
    if (!lane) begin
      req1_valid = 1'b1; req1_use_high = uh; req1_unsigned = uns; req1_x = x; req1_y = y;
    end else begin
      req2_valid = 1'b1; req2_use_high = uh; req2_unsigned = uns; req2_x = x; req2_y = y;
    end
  endtask

  task automatic wait_rsp(input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin step(); n++; end
    if (!rsp_valid) chk("rsp_timeout", 67'(rsp_valid), 67'(1));
  endtask

  task automatic watch_no_rsp(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      seen |= rsp_valid;
      step();
    end
    chk(tag, 67'(seen), 67'(0));
  endtask

  // Full operation with latency, bus, response and backpressure checks.
  task automatic run_op(input bit lane, input bit uh, input bit uns,
                        input logic [31:0] x, input logic [31:0] y,
                        input int lat, input int hold);
    int n;
    logic [31:0] e;
    e = ref_mul(uh, uns, x, y);
    mul_lat = lat;
    set_req(lane, uh, uns, x, y);
    #1;
    chk("accept_rdy", 67'(lane ? req2_ready : req1_ready), 67'(1));
    step();
    req1_valid = 1'b0; req2_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 12) begin
      chk("run_bus", mul_req_bus, {1'b1, uh, uns, x, y});
      chk("run_busy", 67'(busy), 67'(1));
      step(); n++;
    end
    chk("latency", 67'(n), 67'(lat + 1));
    chk("rsp_data", 67'(rsp_data), 67'(e));
    chk("rsp_lane", 67'(rsp_lane), 67'(lane));
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", 67'(rsp_valid), 67'(1));
      chk("hold_data", 67'(rsp_data), 67'(e));
      chk("hold_bus", mul_req_bus, 67'(0));
      chk("hold_rdy", 67'({req1_ready, req2_ready}), 67'(0));
      chk("hold_busy", 67'(busy), 67'(1));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("idle_busy", 67'(busy), 67'(0));
    chk("idle_valid", 67'(rsp_valid), 67'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_busy", 67'(busy), 67'(0));
    chk("rst_valid", 67'(rsp_valid), 67'(0));
    chk("rst_data", 67'(rsp_data), 67'(0));
    chk("rst_lane", 67'(rsp_lane), 67'(0));
    chk("rst_bus", mul_req_bus, 67'(0));
    #10 reset = 1'b0;
    #1;
    chk("rst_r1rdy", 67'(req1_ready), 67'(1));
    step();

    run_op(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd7, 3, 0);
    run_op(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 0);
    run_op(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 0);
    chk("tp1_const", 67'(ref_mul(1'b0, 1'b0, 32'hFFFF_FFFD, 32'd7)), 67'(32'hFFFF_FFEB));

    // Both lanes valid together: lane 1 wins, lane 2 goes next.
    mul_lat = 3;
    set_req(1'b0, 1'b0, 1'b0, 32'd6, 32'd7);
    set_req(1'b1, 1'b0, 1'b0, 32'd5, 32'd5);
    #1;
    chk("both_r1", 67'(req1_ready), 67'(1));
    chk("both_r2", 67'(req2_ready), 67'(0));
    step();
    req1_valid = 1'b0;
    wait_rsp(10);
    chk("both_d1", 67'(rsp_data), 67'(42));
    chk("both_l1", 67'(rsp_lane), 67'(0));
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    chk("both_r2_idle", 67'(req2_ready), 67'(1));
    step();
    req2_valid = 1'b0;
    chk("both_busy2", 67'(busy), 67'(1));
    wait_rsp(10);
    chk("both_d2", 67'(rsp_data), 67'(25));
    chk("both_l2", 67'(rsp_lane), 67'(1));
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

    run_op(1'b0, 1'b0, 1'b1, 32'd1000, 32'd3000, 3, 5);

    // Flush in the second RUN cycle, then a flush cycle with a pending request.
    mul_lat = 3;
    set_req(1'b0, 1'b0, 1'b0, 32'd3, 32'd5);
    step();
    req1_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    chk("fl1_busy", 67'(busy), 67'(0));
    chk("fl1_bus", mul_req_bus, 67'(0));
    set_req(1'b0, 1'b0, 1'b0, 32'd9, 32'd9);
    #1;
    chk("fl1_r1rdy", 67'(req1_ready), 67'(0));
    step();
    req1_valid = 1'b0;
    flush = 1'b0;
    chk("fl1_noacc", 67'(busy), 67'(0));
    watch_no_rsp("fl1_norsp", 6);

    // Flush coincident with mul_ok.
    set_req(1'b1, 1'b0, 1'b1, 32'd7, 32'd8);
    step();
    req2_valid = 1'b0;
    step(); step();
    chk("fl2_okseen", 67'(mul_ok_m), 67'(1));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl2_busy", 67'(busy), 67'(0));
    chk("fl2_valid", 67'(rsp_valid), 67'(0));
    watch_no_rsp("fl2_norsp", 6);
    run_op(1'b0, 1'b0, 1'b0, 32'd3, 32'd4, 3, 0);

    // Asynchronous reset between edges while in RUN.
    set_req(1'b0, 1'b0, 1'b0, 32'd11, 32'd13);
    step();
    req1_valid = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    chk("arst_bus", mul_req_bus, 67'(0));
    chk("arst_valid", 67'(rsp_valid), 67'(0));
    chk("arst_busy", 67'(busy), 67'(0));
    chk("arst_data", 67'(rsp_data), 67'(0));
    #2 reset = 1'b0;
    step();
    chk("arst_r1rdy", 67'(req1_ready), 67'(1));
    chk("arst_idle", 67'(busy), 67'(0));

    for (int i = 0; i < 40; i++) begin
      logic [31:0] rx, ry;
      rx = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      ry = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             rx, ry, $urandom_range(1, 4), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
